// File: rtl/bit_stuff_tx.sv
// Bit-stuffing serial transmitter: sends DATA_W-bit words LSB first and forces a complement
// bit after RUN_MAX identical bits. Define FRAME_FLAG_EN to add the optional start-of-frame flag.
module bit_stuff_tx #(
  parameter int DATA_W  = 8,
  parameter int RUN_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
`ifdef FRAME_FLAG_EN
  input  logic              frame_start,
`endif
  output logic              din_ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              stuffed,
  output logic              busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int RC_W  = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [RC_W-1:0]  RUN_LIM  = RC_W'(RUN_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef FRAME_FLAG_EN
    STUFF = 2'd2,
    FLAG  = 2'd3
`else
    STUFF = 2'd2
`endif
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic              last_bit;
  logic [RC_W-1:0]   run_cnt;
  logic              stuff_pend;
  logic              last_slot;

  logic              accept;
  logic              flag_done;
  logic              start_flag;
  logic              flag_step;
  logic              do_load;
  logic              do_stuff;
  logic              do_idle;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_word;
  logic              ld_bit;
  logic              base_lb;
  logic [RC_W-1:0]   base_rc;
  logic [RC_W:0]     ld_run;
  logic              ld_stuff;
  logic              ld_last;

  // Returns {last_bit, run_cnt} after sending bit b on top of run state (lb, rc).
  function automatic logic [RC_W:0] run_next(input logic b, input logic lb,
                                             input logic [RC_W-1:0] rc);
    if (b == lb) return {lb, rc + RC_W'(1)};
    else         return {b, RC_W'(1)};
  endfunction

  // last_slot is a registered state flag, so din_ready never depends on din_valid.
  assign din_ready = (state == IDLE) || last_slot;
  assign accept    = din_valid && din_ready;

`ifdef FRAME_FLAG_EN
  localparam logic [3:0] FLAG_LAST = 4'(RUN_MAX + 2);
  logic [3:0] flag_cnt;

  assign flag_done  = (state == FLAG) && (flag_cnt == FLAG_LAST);
  assign flag_step  = (state == FLAG) && !flag_done;
  assign start_flag = accept && frame_start;
`else
  assign flag_done  = 1'b0;
  assign flag_step  = 1'b0;
  assign start_flag = 1'b0;
`endif

  always_comb begin
    do_stuff = (state == SHIFT) && !last_slot && stuff_pend;
    do_idle  = last_slot && !accept;
    do_load  = (accept && !start_flag) || flag_done ||
               (!last_slot && (((state == SHIFT) && !stuff_pend) || (state == STUFF)));
    ld_idx   = (accept || flag_done) ? '0 : bit_idx + IDX_W'(1);
    ld_word  = accept ? din : shreg;
    ld_bit   = ld_word[ld_idx];
    // The flag leaves the line as a single 0, so data resumes from run state (0, 1).
    base_lb  = flag_done ? 1'b0 : last_bit;
    base_rc  = flag_done ? RC_W'(1) : run_cnt;
    ld_run   = run_next(ld_bit, base_lb, base_rc);
    ld_stuff = (ld_run[RC_W-1:0] == RUN_LIM);
    ld_last  = !ld_stuff && (ld_idx == LAST_IDX);
  end

  // Output stage: every register below describes the slot currently on sout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      last_bit   <= 1'b0;
      run_cnt    <= '0;
      stuff_pend <= 1'b0;
      last_slot  <= 1'b0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      stuffed    <= 1'b0;
      busy       <= 1'b0;
`ifdef FRAME_FLAG_EN
      flag_cnt   <= '0;
`endif
    end else if (do_load) begin
      state      <= SHIFT;
      sout       <= ld_bit;
      sout_valid <= 1'b1;
      stuffed    <= 1'b0;
      busy       <= 1'b1;
      bit_idx    <= ld_idx;
      last_bit   <= ld_run[RC_W];
      run_cnt    <= ld_run[RC_W-1:0];
      stuff_pend <= ld_stuff;
      last_slot  <= ld_last;
      if (accept) shreg <= din;
    end else if (do_stuff) begin
      state      <= STUFF;
      sout       <= ~last_bit;
      stuffed    <= 1'b1;
      last_bit   <= ~last_bit;
      run_cnt    <= RC_W'(1);
      stuff_pend <= 1'b0;
      last_slot  <= (bit_idx == LAST_IDX);
    end else if (do_idle) begin
      state      <= IDLE;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      stuffed    <= 1'b0;
      busy       <= 1'b0;
      last_slot  <= 1'b0;
    end
`ifdef FRAME_FLAG_EN
    else if (start_flag) begin
      state      <= FLAG;
      shreg      <= din;
      sout       <= 1'b0;
      sout_valid <= 1'b1;
      stuffed    <= 1'b0;
      busy       <= 1'b1;
      flag_cnt   <= '0;
      stuff_pend <= 1'b0;
      last_slot  <= 1'b0;
    end else if (flag_step) begin
      flag_cnt   <= flag_cnt + 4'd1;
      sout       <= ((flag_cnt + 4'd1) != FLAG_LAST);
    end
`endif
  end

endmodule

// File: tb/tb_bit_stuff_tx.sv
// Directed bench for bit_stuff_tx (DATA_W=8, RUN_MAX=3); the flag case runs when
// FRAME_FLAG_EN is defined.
module tb_bit_stuff_tx;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       sout_valid;
  logic       stuffed;
  logic       busy;
`ifdef FRAME_FLAG_EN
  logic       frame_start;
`endif

  int passes;
  int total;
  int acc_cnt;
  int acc0;

  bit_stuff_tx #(.DATA_W(8), .RUN_MAX(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
`ifdef FRAME_FLAG_EN
    .frame_start(frame_start),
`endif
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .stuffed    (stuffed),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change just after rising edges, so they are stable here.
  initial acc_cnt = 0;
  always @(negedge clk) if (din_valid && din_ready && !reset) acc_cnt <= acc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    reset = 1'b1;
    din_valid = 1'b0;
    #2;
    check({tag, " rst sout_valid"}, 32'(sout_valid), 32'd0);
    check({tag, " rst stuffed"},    32'(stuffed),    32'd0);
    check({tag, " rst busy"},       32'(busy),       32'd0);
    check({tag, " rst sout"},       32'(sout),       32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check({tag, " post-rst din_ready"}, 32'(din_ready), 32'd1);
  endtask

  // Present one word at the next edge and drop din_valid once it is taken.
  task automatic send_one(input logic [7:0] w, input logic fs);
    @(posedge clk); #1;
    din = w;
    din_valid = 1'b1;
`ifdef FRAME_FLAG_EN
    frame_start = fs;
`else
    if (fs) $display("frame_start ignored in this build");
`endif
    @(posedge clk); #1;
    din_valid = 1'b0;
    din = 8'hA5;
`ifdef FRAME_FLAG_EN
    frame_start = 1'b0;
`endif
  endtask

  // Bit i of es/est/erdy is the expected sout/stuffed/din_ready in slot i+1.
  task automatic run_slots(input string tag, input int n, input logic [31:0] es,
                           input logic [31:0] est, input logic [31:0] erdy, input int drop_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s sout_valid[%0d]", tag, i + 1), 32'(sout_valid), 32'd1);
      check($sformatf("%s sout[%0d]", tag, i + 1),       32'(sout),       32'(es[i]));
      check($sformatf("%s stuffed[%0d]", tag, i + 1),    32'(stuffed),    32'(est[i]));
      check($sformatf("%s din_ready[%0d]", tag, i + 1),  32'(din_ready),  32'(erdy[i]));
      if (i == drop_at) begin
        @(posedge clk); #1;
        din_valid = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, " end sout_valid"}, 32'(sout_valid), 32'd0);
    check({tag, " end sout"},       32'(sout),       32'd0);
    check({tag, " end busy"},       32'(busy),       32'd0);
    check({tag, " end din_ready"},  32'(din_ready),  32'd1);
  endtask

  initial begin
    passes = 0;
    total = 0;
    reset = 1'b1;
    din = 8'h00;
    din_valid = 1'b0;
`ifdef FRAME_FLAG_EN
    frame_start = 1'b0;
`endif

    // 8'hFF: stuffs in slots 4 and 8, ready only in the final slot.
    do_reset("ff");
    send_one(8'hFF, 1'b0);
    run_slots("ff", 10, 32'h377, 32'h088, 32'h200, -1);

    // 8'h55: alternating bits, never stuffed.
    do_reset("55");
    send_one(8'h55, 1'b0);
    run_slots("55", 8, 32'h055, 32'h000, 32'h080, -1);

    // Two 8'h00 words back to back with din_valid held.
    do_reset("00x2");
    @(posedge clk); #1;
    din = 8'h00;
    din_valid = 1'b1;
    acc0 = acc_cnt;
    @(posedge clk); #1;
    run_slots("00x2", 21, 32'h88888, 32'h88888, 32'h100200, 9);
    check("00x2 acceptances", 32'(acc_cnt - acc0), 32'd2);

    // 8'hE0: final data bit completes a run, so a trailing stuff ends the word.
    do_reset("e0");
    send_one(8'hE0, 1'b0);
    run_slots("e0", 10, 32'h1C8, 32'h208, 32'h200, -1);

    // Reset asserted during the first stuff slot of 8'hFF.
    do_reset("midrst");
    send_one(8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("midrst sout[%0d]", i + 1),    32'(sout),    32'(i != 3));
      check($sformatf("midrst stuffed[%0d]", i + 1), 32'(stuffed), 32'(i == 3));
    end
    reset = 1'b1;
    #1;
    check("midrst async sout_valid", 32'(sout_valid), 32'd0);
    check("midrst async stuffed",    32'(stuffed),    32'd0);
    check("midrst async busy",       32'(busy),       32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst din_ready", 32'(din_ready), 32'd1);
    send_one(8'h55, 1'b0);
    run_slots("midrst 55", 8, 32'h055, 32'h000, 32'h080, -1);

`ifdef FRAME_FLAG_EN
    // Flag 0,1,1,1,1,0 then 8'h00 resuming from run state (0, 1).
    do_reset("flag");
    send_one(8'h00, 1'b1);
    run_slots("flag", 17, 32'h1111E, 32'h11100, 32'h10000, -1);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
